regfile_bank: RTL and testbench

//   16-entry x 16-bit register file that sources the r0..r15 operand buses of
//   the datapath's 16:1 read-select muxes.
//   One synchronous write port loads ALU results.
//   A sequential clear engine re-initialises all entries, one per cycle, under
//   a busy flag.
//   All storage is registered; reads are the raw register outputs, with no

---
 rtl/regfile_bank.sv | 116 +++++++++++
 tb/tb_regfile_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_bank.sv
// 16 x WIDTH register file with one write port and a one-entry-per-cycle clear sweep.
// Optional REGFILE_ZERO_R0_EN hardwires entry 0 to zero and discards writes to it.
module regfile_bank #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr_start,
    output logic             busy,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15
);

`ifdef REGFILE_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t           r_state;
    logic [3:0]       r_ptr;
    logic             r_busy;
    logic [15:0]      w_wr_en;
    logic [15:0]      w_clr_en;
    logic [WIDTH-1:0] w_q [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= 4'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_ptr <= r_ptr + 4'd1;
                    // Last entry cleared: pointer wraps to 0 on its own.
                    if (r_ptr == 4'd15) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_ent
            assign w_wr_en[k]  = (r_state == S_IDLE) && we && (wsel == 4'(k));
            assign w_clr_en[k] = (r_state == S_CLEAR) && (r_ptr == 4'(k));

            if (ZERO_R0 && (k == 0)) begin : g_zero
                assign w_q[k] = '0;
            end else begin : g_reg
                logic [WIDTH-1:0] r_val;
                always_ff @(posedge clk) begin
                    if (reset || w_clr_en[k])
                        r_val <= CLEAR_VAL;
                    else if (w_wr_en[k])
                        r_val <= wdata;
                end
                assign w_q[k] = r_val;
            end
        end
    endgenerate

    assign busy = r_busy;
    assign r0   = w_q[0];
    assign r1   = w_q[1];
    assign r2   = w_q[2];
    assign r3   = w_q[3];
    assign r4   = w_q[4];
    assign r5   = w_q[5];
    assign r6   = w_q[6];
    assign r7   = w_q[7];
    assign r8   = w_q[8];
    assign r9   = w_q[9];
    assign r10  = w_q[10];
    assign r11  = w_q[11];
    assign r12  = w_q[12];
    assign r13  = w_q[13];
    assign r14  = w_q[14];
    assign r15  = w_q[15];

endmodule

// File: tb/tb_regfile_bank.sv
// Randomized + directed bench for regfile_bank against a countdown-based sweep model.
module tb_regfile_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  wsel = 4'd0;
    logic [15:0] wdata = 16'h0;
    logic        clr_start = 1'b0;
    logic        busy;
    logic [15:0] dut_r [16];

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_reg [16];
    int          m_left = 0;

    always #5 clk = ~clk;

    regfile_bank dut (
        .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata),
        .clr_start(clr_start), .busy(busy),
        .r0(dut_r[0]),   .r1(dut_r[1]),   .r2(dut_r[2]),   .r3(dut_r[3]),
        .r4(dut_r[4]),   .r5(dut_r[5]),   .r6(dut_r[6]),   .r7(dut_r[7]),
        .r8(dut_r[8]),   .r9(dut_r[9]),   .r10(dut_r[10]), .r11(dut_r[11]),
        .r12(dut_r[12]), .r13(dut_r[13]), .r14(dut_r[14]), .r15(dut_r[15])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a sweep is "m_left entries still to clear", entry 16-m_left goes next.
    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_reg[16 - m_left] = 16'h0;
            m_left--;
        end else begin
            if (we) m_reg[wsel] = wdata;
            if (clr_start) m_left = 16;
        end
`ifdef REGFILE_ZERO_R0_EN
        m_reg[0] = 16'h0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("r%0d", i), dut_r[i], m_reg[i]);
        chk("busy", {15'd0, busy}, {15'd0, (m_left > 0)});
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] d);
        we = 1'b1; wsel = sel; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        int bcnt;
        // Reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) chk("reset_val", dut_r[i], 16'h0);
        chk("reset_busy", {15'd0, busy}, 16'h0);

        // Write latency and hold
        wr(4'h5, 16'hBEEF);
        chk("wr_r5", dut_r[5], 16'hBEEF);
        chk("wr_r4", dut_r[4], 16'h0);
        chk("wr_r6", dut_r[6], 16'h0);
        wdata = 16'h1234;
        tick();
        chk("hold_r5", dut_r[5], 16'hBEEF);

        // Full sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 16'hA000 + 16'(i));
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            bcnt++;
            tick();
            if (i < 16) chk("sweep_cleared", dut_r[i], 16'h0);
            if (i < 15) chk("sweep_pending", dut_r[i+1], 16'hA000 + 16'(i+1));
        end
        chk("sweep_busy_len", 16'(bcnt), 16'd16);

        // Write and clr_start during clear
        wr(4'hF, 16'h7777);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        bcnt = 1;
        repeat (2) begin tick(); bcnt++; end
        we = 1'b1; wsel = 4'hF; wdata = 16'h5555; clr_start = 1'b1;
        tick(); bcnt++;
        we = 1'b0; clr_start = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin tick(); bcnt++; end
        chk("wdc_busy_len", 16'(bcnt - 1), 16'd16);
        chk("wdc_r15", dut_r[15], 16'h0);

        // Reset mid-sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 16'hC000 | 16'(i));
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", {15'd0, busy}, 16'h0);
        for (int i = 0; i < 16; i++) chk("rst_mid_val", dut_r[i], 16'h0);
        wr(4'h2, 16'h2222);
        chk("post_rst_r2", dut_r[2], 16'h2222);
        repeat (4) tick();

        // Entry 0 write
        wr(4'h0, 16'hFFFF);
`ifdef REGFILE_ZERO_R0_EN
        chk("r0_zero", dut_r[0], 16'h0);
`else
        chk("r0_write", dut_r[0], 16'hFFFF);
`endif

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            we        = 1'($urandom_range(0, 1));
            wsel      = 4'($urandom_range(0, 15));
            wdata     = 16'($urandom);
            clr_start = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; we = 1'b0; clr_start = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("final_idle", {15'd0, busy}, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
